// File: rtl/fifo_ser_pkg.sv
// Shared types and default widths for the FIFO word serializer.
package fifo_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    localparam int SER_DATA_WIDTH = 64;
    localparam int SER_BEAT_WIDTH = 16;

endpackage

// File: rtl/fifo_word_serializer.sv
// Dequeues one DATA_WIDTH word from the upstream FIFO and emits it as BEATS narrow beats.
// Define FIFO_WORD_SERIALIZER_MSB_FIRST_EN to emit the most-significant beat first.
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_WIDTH = SER_DATA_WIDTH,
    parameter int BEAT_WIDTH = SER_BEAT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [DATA_WIDTH-1:0] in_first,
    input  logic                  in_first__RDY,
    input  logic                  in_deq__RDY,
    output logic                  in_deq__ENA,
    input  logic                  out_enq__RDY,
    output logic                  out_enq__ENA,
    output logic [BEAT_WIDTH-1:0] out_enq_v,
    output logic                  out_enq_last
);

    localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
    // A one-beat word still needs a 1-bit counter to keep the declarations legal.
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    ser_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic                  fire, fire_last, load;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        if (load) begin
            // Covers both the first word and the zero-bubble reload on the last beat.
            shreg_nxt = in_first;
            cnt_nxt   = '0;
            state_nxt = SEND;
        end else if (fire_last) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end else if (fire) begin
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
            shreg_nxt = shreg << BEAT_WIDTH;
`else
            shreg_nxt = shreg >> BEAT_WIDTH;
`endif
            cnt_nxt   = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        fire      = nRST && (state == SEND) && out_enq__RDY;
        fire_last = fire && (cnt == CNT_LAST);
        load      = nRST && in_first__RDY && in_deq__RDY && ((state == IDLE) || fire_last);

        in_deq__ENA  = load;
        out_enq__ENA = fire;
        out_enq_last = fire_last;
`ifdef FIFO_WORD_SERIALIZER_MSB_FIRST_EN
        out_enq_v    = shreg[DATA_WIDTH-1 -: BEAT_WIDTH];
`else
        out_enq_v    = shreg[BEAT_WIDTH-1:0];
`endif
    end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Downstream consumer of the one-element 64-bit FIFO stage. It dequeues one 64-bit word through the FIFO's first/deq methods and emits it as BEATS narrower beats into the next stage's enq method. It uses ENA/RDY method handshakes on both sides and sustains full throughput: one beat per cycle, with no bubble between consecutive words.

Parameters:
DATA_WIDTH, 64, width of the input word (FIFO element width)
BEAT_WIDTH, 16, width of each output beat; must divide DATA_WIDTH exactly
BEATS (localparam), DATA_WIDTH/BEAT_WIDTH, beats per word (default 4)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
in_first  input  DATA_WIDTH  upstream FIFO head word
in_first__RDY  input  1  upstream head valid
in_deq__RDY  input  1  upstream deq method ready
in_deq__ENA  output  1  invoke upstream deq this cycle
out_enq__RDY  input  1  downstream enq method ready
out_enq__ENA  output  1  invoke downstream enq this cycle
out_enq_v  output  BEAT_WIDTH  beat payload, valid when out_enq__ENA is high
out_enq_last  output  1  high with the final beat of each word

Behaviour:
- Reset: one clock CLK; reset nRST is asynchronous and active-low.
  - While nRST is low: state=IDLE, beat counter=0, shift register=0.
  - Outputs in_deq__ENA, out_enq__ENA, out_enq_last and out_enq_v all read 0 immediately. Both ENAs are gated by nRST.
- Registers:
  - state {IDLE, SEND}
  - cnt, $clog2(BEATS) bits
  - shreg, DATA_WIDTH bits
- load condition: load = in_first__RDY && in_deq__RDY && (state==IDLE || fire_last).
  - fire = out_enq__ENA.
  - fire_last = fire && cnt==BEATS-1.
- in_deq__ENA = load, combinational, in the same cycle as the load.
  - On load: shreg<=in_first, cnt<=0, state<=SEND.
- out_enq__ENA = (state==SEND) && out_enq__RDY.
  - out_enq_v = shreg[BEAT_WIDTH-1:0] (LSB beat first).
  - out_enq_last = out_enq__ENA && cnt==BEATS-1.
- On fire, not last: shreg shifts right by BEAT_WIDTH; cnt<=cnt+1.
- On fire_last:
  - with load in the same cycle: reload from in_first, cnt<=0, stay in SEND (back-to-back, zero bubble).
  - without load: state<=IDLE, cnt<=0.
- Backpressure: out_enq__RDY low holds shreg, cnt and state unchanged. No beat is dropped or duplicated.
- Latency: the first beat is offered the cycle after the load, so word-in to first beat-out is 1 cycle. A word completes BEATS cycles after its load if unstalled.
- Upstream empty (in_first__RDY=0) in IDLE: no deq; stay IDLE.
- Ordering: in_deq__ENA is never asserted without in_first__RDY && in_deq__RDY. out_enq__ENA is never asserted without out_enq__RDY.
- Reset mid-word: the partially emitted word is discarded; after release, the block restarts in IDLE with a fresh load.
- BEATS==1: every fire is fire_last, giving pass-through with 1 cycle of latency.

Optional Feature:
- Macro: FIFO_WORD_SERIALIZER_MSB_FIRST_EN.
- Defined: beats are emitted most-significant first.
  - out_enq_v = shreg[DATA_WIDTH-1 -: BEAT_WIDTH].
  - shreg shifts left by BEAT_WIDTH on each non-last fire.
- Undefined (default): LSB-first, as described in Behaviour.
- Handshake, latency and out_enq_last timing are identical in both builds.

Decomposition:
- Shared package fifo_ser_pkg contains:
  - the state enum typedef ser_state_t {IDLE, SEND};
  - default width constants SER_DATA_WIDTH=64 and SER_BEAT_WIDTH=16.
- No sub-module: counter and shifter are trivially inline, giving a single module.

Test Plan:
1. Reset, then a single word: in_first=64'h0123_4567_89AB_CDEF with both RDYs high.
   - Expect in_deq__ENA=1 for exactly 1 cycle.
   - Expect beats CDEF, 89AB, 4567, 0123 on consecutive cycles, with out_enq_last only on 0123; then IDLE.
2. Back-to-back: FIFO holds 64'h1111_2222_3333_4444, then 64'h5555_6666_7777_8888; out_enq__RDY held high.
   - Expect 8 beats on 8 consecutive cycles.
   - Expect the second in_deq__ENA coincident with beat 1111 (out_enq_last=1).
3. Backpressure: drop out_enq__RDY for 3 cycles after the first beat.
   - Expect out_enq__ENA=0 and no state change during the stall.
   - Expect the remaining beats to resume in order with none lost or repeated.
4. Upstream empty: in_first__RDY=0 for 10 cycles.
   - Expect in_deq__ENA=0 and out_enq__ENA=0 throughout.
5. Async reset mid-word: assert nRST low between clock edges after 2 beats.
   - Expect ENAs to go 0 immediately, before the next edge.
   - After release with a new word 64'hAAAA_BBBB_CCCC_DDDD, expect first beat DDDD.
6. With FIFO_WORD_SERIALIZER_MSB_FIRST_EN defined, repeat scenario 1.
   - Expect order 0123, 4567, 89AB, CDEF, with out_enq_last on CDEF.
